// File: rtl/apb_gpio_arbiter.sv
// rtl/apb_gpio_arbiter.sv - two-requester round-robin APB master for a shared GPIO slave
// Back-to-back transfers re-arbitrate in the completing ACCESS cycle; stalled ACCESS aborts after TIMEOUT cycles.
module apb_gpio_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t              state_q, state_d;
  logic                prio_q, prio_d;
  logic                owner_q, owner_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                timeout_hit, done, window, gnt;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    req_ready   = 2'b00;

    timeout_hit = (TIMEOUT != 0) && (state_q == ST_ACCESS) && !pready && (cnt_q == CNT_LAST);
    done        = (state_q == ST_ACCESS) && (pready || timeout_hit);
    window      = (state_q == ST_IDLE) || done;
    // prio_q names the requester that wins a tie, i.e. the one not granted last
    gnt         = (&req_valid) ? prio_q : req_valid[1];

    case (state_q)
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
      end
      ST_ACCESS: begin
        if (done) state_d = ST_IDLE;
        else      cnt_d   = cnt_q + 1'b1;
      end
      default: ;
    endcase

    if (done) begin
      rsp_valid_d[owner_q] = 1'b1;
      rsp_err_d            = !pready;
      rsp_rdata_d          = (pready && !pwrite_q) ? prdata : '0;
    end

    if (window && (|req_valid)) begin
      req_ready[gnt] = 1'b1;
      prio_d         = ~gnt;
      owner_d        = gnt;
      pwrite_d       = req_write[gnt];
      paddr_d        = gnt ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      pwdata_d       = gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      state_d        = ST_SETUP;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = (state_q != ST_IDLE);
  assign penable   = (state_q == ST_ACCESS);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_gpio_arbiter.md
Name: apb_gpio_arbiter

Overview:
- APB master front-end that shares one APB GPIO slave between two requesters, e.g. CPU port 0 and debug/DMA port 1.
- Round-robin arbitration between the requesters.
- Sequences APB SETUP/ACCESS phases, honours pready and aborts stalled transfers with a timeout.
- Sits between the requesters and the GPIO register slave: output/output-enable registers at paddr 0/1, input register elsewhere.

Parameters:
ADDR_W, 10, APB address width
DATA_W, 32, APB data width
TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
pclk  in  1  clock
preset  in  1  asynchronous active-high reset
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester accept; transfer taken when valid&ready
req_write  in  2  1=write, 0=read
req_addr  in  2*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  2*DATA_W  requester i at [i*DATA_W +: DATA_W]
rsp_valid  out  2  one-hot, one-cycle completion pulse to the owning requester
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  timeout abort flag, valid with rsp_valid
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready; tie high for zero-wait slaves

Behaviour:
- Reset (async, immediate):
  - State IDLE; round-robin pointer favours requester 0.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, timeout counter all 0.
  - Reset mid-transfer drops the transfer; no rsp pulse is issued for it.
- States:
  - IDLE: psel=0, penable=0.
  - SETUP: psel=1, penable=0. Always exactly one cycle, then ACCESS.
  - ACCESS: psel=1, penable=1. Held until pready=1 or timeout.
- Accept window: state==IDLE, or state==ACCESS with the transfer completing this cycle (pready=1 or timeout).
  - req_ready is combinational: only the arbitration winner sees ready=1, and only inside the window. At most one bit set.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the requester not granted last wins.
  - Pointer updates only on an accepted handshake.
- On accept:
  - Capture pwrite, paddr, pwdata and owner id into registers.
  - Next state SETUP. This includes back-to-back transfers directly from ACCESS, with no IDLE cycle between.
  - paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS.
- Completion (edge where ACCESS & pready):
  - Next cycle: rsp_valid[owner]=1 for exactly one cycle.
  - rsp_rdata = prdata sampled at completion; 0 for writes.
  - rsp_err=0.
- Timeout (TIMEOUT>0):
  - Counter clears on entering ACCESS and increments on each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT-1 with pready=0, the transfer ends that edge.
  - Next cycle: rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0.
  - The bus leaves ACCESS (penable drops) exactly as on normal completion.
- Zero-wait latency:
  - Accept at edge N; SETUP in cycle N+1; ACCESS in cycle N+2 completes; rsp_valid in cycle N+3.
  - Back-to-back throughput: one transfer per 2 cycles.
- No transfer completes without being accepted. Requesters may drop req_valid before acceptance without effect.
- Outside SETUP/ACCESS, paddr, pwrite and pwdata hold their last value; psel is the only qualifier.

Test Plan:
- Reset then requester 0 write addr 0 data 0xA5A5_0001, pready=1 -> cycle sequence: psel=1/penable=0, then psel=1/penable=1 with paddr=0, pwrite=1, pwdata=0xA5A5_0001; rsp_valid=2'b01 next cycle with rsp_err=0.
- Requester 1 read addr 2, prdata=0x1234_5678 -> rsp_valid=2'b10, rsp_rdata=0x1234_5678; a write completion returns rsp_rdata=0.
- Both valid every cycle, 4 transfers each, pready=1 -> grants alternate 0,1,0,1,... with no IDLE cycle between transfers; 8 rsp pulses total, one per 2 cycles.
- pready held low 3 ACCESS cycles then high -> psel/penable/paddr stable throughout; single rsp pulse after the pready cycle; rsp_err=0.
- TIMEOUT=16, pready stuck low -> exactly 16 ACCESS cycles, then rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0; the next queued request starts SETUP immediately.
- preset asserted during ACCESS of a requester 0 read -> psel, penable and rsp_valid drop to 0 asynchronously; no rsp after release; the first post-reset contention is won by requester 0.
